// File: rtl/knight_pkg.sv
// rtl/knight_pkg.sv - shared types and constants for the KnightsTour command path
package knight_pkg;

    // Arbiter ownership phases: waiting, offering cmd, move running, reply
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        EXEC  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam logic [7:0] ACK_CODE = 8'hA5;
    localparam logic [7:0] TMO_CODE = 8'hEE;

    // Command opcodes live in cmd[15:12]
    localparam logic [3:0]  OP_CAL_GYRO = 4'h2;
    localparam logic [3:0]  OP_MOVE     = 4'h4;
    localparam logic [3:0]  OP_FANFARE  = 4'h5;
    localparam logic [15:0] CAL_GYRO    = {OP_CAL_GYRO, 12'h000};

    // Short watchdog for simulation, full length for the real robot
    function automatic int wdog_width(input bit fast_sim);
        return fast_sim ? 16 : 26;
    endfunction

endpackage

// File: rtl/cmd_arb_if.sv
// rtl/cmd_arb_if.sv - command sources, cmd_proc and response handshake bundle
interface cmd_arb_if;

    logic [15:0] rmt_cmd;
    logic        rmt_cmd_rdy;
    logic        rmt_clr;
    logic [15:0] tour_cmd;
    logic        tour_cmd_rdy;
    logic        tour_clr;
    logic        tour_active;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;
    logic        rmt_resp;
    logic        tour_resp;
    logic        owner;
    logic        busy;
    logic        tmo_err;

    // Arbiter side
    modport master (
        input  rmt_cmd, rmt_cmd_rdy, tour_cmd, tour_cmd_rdy, tour_active,
               clr_cmd_rdy, send_resp,
        output rmt_clr, tour_clr, cmd, cmd_rdy, resp, rmt_resp, tour_resp,
               owner, busy, tmo_err
    );

    // Sources and cmd_proc side
    modport slave (
        output rmt_cmd, rmt_cmd_rdy, tour_cmd, tour_cmd_rdy, tour_active,
               clr_cmd_rdy, send_resp,
        input  rmt_clr, tour_clr, cmd, cmd_rdy, resp, rmt_resp, tour_resp,
               owner, busy, tmo_err
    );

endinterface

// File: rtl/arb_wdog.sv
// rtl/arb_wdog.sv - move watchdog: free-running up counter with all-ones expiry
module arb_wdog #(
    parameter int WIDTH = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    // Clear wins over count so a fresh move always starts from zero
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = &cnt_q;

endmodule

// File: rtl/cmd_arb.sv
// rtl/cmd_arb.sv - grants cmd_proc to the remote or tour source and routes the reply
module cmd_arb
    import knight_pkg::*;
#(
    parameter bit         FAST_SIM = 1'b1,
    parameter logic [7:0] ACK      = ACK_CODE,
    parameter logic [7:0] TMO      = TMO_CODE
) (
    input logic       clk,
    input logic       rst,
    cmd_arb_if.master bus
);

    localparam int WD_W = wdog_width(FAST_SIM);

    arb_state_t  state_q, state_d;
    logic [15:0] cmd_q, cmd_d;
    logic        cmd_rdy_q, cmd_rdy_d;
    logic        owner_q, owner_d;
    logic        rmt_clr_q, rmt_clr_d;
    logic        tour_clr_q, tour_clr_d;
    logic [7:0]  resp_q, resp_d;
    logic        tmo_err_q, tmo_err_d;
    logic        wd_clr, wd_en, wd_expire;

    arb_wdog #(.WIDTH(WD_W)) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (wd_clr),
        .en     (wd_en),
        .expire (wd_expire)
    );

    // Next-state and datapath decisions; everything holds unless a phase moves it
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        cmd_rdy_d  = cmd_rdy_q;
        owner_d    = owner_q;
        resp_d     = resp_q;
        tmo_err_d  = tmo_err_q;
        rmt_clr_d  = 1'b0;
        tour_clr_d = 1'b0;
        wd_clr     = 1'b0;
        wd_en      = 1'b0;

        case (state_q)
            IDLE: begin
                // Tour wins only while a tour is running or remote is quiet;
                // the losing source keeps its rdy level and is served later
                if (bus.tour_cmd_rdy && (bus.tour_active || !bus.rmt_cmd_rdy)) begin
                    cmd_d      = bus.tour_cmd;
                    owner_d    = 1'b1;
                    tour_clr_d = 1'b1;
                    cmd_rdy_d  = 1'b1;
                    tmo_err_d  = 1'b0;
                    state_d    = ISSUE;
                end else if (bus.rmt_cmd_rdy) begin
                    cmd_d      = bus.rmt_cmd;
                    owner_d    = 1'b0;
                    rmt_clr_d  = 1'b1;
                    cmd_rdy_d  = 1'b1;
                    tmo_err_d  = 1'b0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.clr_cmd_rdy) begin
                    cmd_rdy_d = 1'b0;
                    wd_clr    = 1'b1;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                wd_en = 1'b1;
                // A real completion on the terminal-count cycle still reports ACK
                if (bus.send_resp) begin
                    resp_d  = ACK;
                    state_d = RESP;
                end else if (wd_expire) begin
                    resp_d    = TMO;
                    tmo_err_d = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any move in flight silently
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            cmd_rdy_q  <= 1'b0;
            owner_q    <= 1'b0;
            rmt_clr_q  <= 1'b0;
            tour_clr_q <= 1'b0;
            resp_q     <= '0;
            tmo_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            cmd_rdy_q  <= cmd_rdy_d;
            owner_q    <= owner_d;
            rmt_clr_q  <= rmt_clr_d;
            tour_clr_q <= tour_clr_d;
            resp_q     <= resp_d;
            tmo_err_q  <= tmo_err_d;
        end
    end

    assign bus.cmd       = cmd_q;
    assign bus.cmd_rdy   = cmd_rdy_q;
    assign bus.owner     = owner_q;
    assign bus.rmt_clr   = rmt_clr_q;
    assign bus.tour_clr  = tour_clr_q;
    assign bus.resp      = resp_q;
    assign bus.tmo_err   = tmo_err_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.rmt_resp  = (state_q == RESP) && !owner_q;
    assign bus.tour_resp = (state_q == RESP) && owner_q;

endmodule
